wb_arbiter: RTL and testbench

- Two-master, one-slave Wishbone arbiter. It replaces the static `bus_master_selector_i` steering between the CPU master and the external debug/loader master (`wb_ext`).
- It sits in `soc` between the two masters and the address-decoding mux.
- Ownership is granted round-robin and held for the owner's whole `cyc` period.
- Only the owner's signals reach the slave; the slave's ack and read data return only to the owner.

---
 rtl/wb_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin ownership held for a full cyc period.
// Optional stall timeout is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter #(
    parameter int unsigned WB_DATA_WIDTH  = 32,
    parameter int unsigned WB_ADDR_WIDTH  = 32,
    parameter int unsigned WB_SEL_WIDTH   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
    input  logic                     m0_we_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_cyc_i,
    output logic                     m0_ack_o,
    output logic [WB_DATA_WIDTH-1:0] m0_data_o,
    input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
    input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
    input  logic                     m1_we_i,
    input  logic                     m1_stb_i,
    input  logic                     m1_cyc_i,
    output logic                     m1_ack_o,
    output logic [WB_DATA_WIDTH-1:0] m1_data_o,
    output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
    output logic [WB_DATA_WIDTH-1:0] s_data_o,
    output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
    output logic                     s_we_o,
    output logic                     s_stb_o,
    output logic                     s_cyc_o,
    input  logic                     s_ack_i,
    input  logic [WB_DATA_WIDTH-1:0] s_data_i,
    output logic [1:0]               grant_o,
    output logic                     timeout_o,
    input  logic                     timeout_clear_i
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   own0, own1;
    logic   stb_raw, cyc_raw;
    logic   tmo_fire;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_d = last_q ? OWN0 : OWN1;
                else if (m0_cyc_i)        state_d = OWN0;
                else if (m1_cyc_i)        state_d = OWN1;
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    last_d  = 1'b0;
                    state_d = m1_cyc_i ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    last_d  = 1'b1;
                    state_d = m0_cyc_i ? OWN0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Reset gates the bus combinationally so nothing leaks out during the reset cycle.
    assign own0    = (state_q == OWN0) && !rst_i;
    assign own1    = (state_q == OWN1) && !rst_i;
    assign grant_o = {state_q == OWN1, state_q == OWN0};

    always_comb begin
        s_addr_o = '0;
        s_data_o = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        stb_raw  = 1'b0;
        cyc_raw  = 1'b0;
        if (own0) begin
            s_addr_o = m0_addr_i;
            s_data_o = m0_data_i;
            s_sel_o  = m0_sel_i;
            s_we_o   = m0_we_i;
            stb_raw  = m0_stb_i;
            cyc_raw  = m0_cyc_i;
        end else if (own1) begin
            s_addr_o = m1_addr_i;
            s_data_o = m1_data_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            stb_raw  = m1_stb_i;
            cyc_raw  = m1_cyc_i;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    assign tmo_fire = (own0 || own1) && stb_raw && (cnt_q == TMO_LIMIT);

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (state_d != state_q || !stb_raw || s_ack_i || tmo_fire) cnt_d = '0;
        timeout_d = timeout_q;
        if (timeout_clear_i) timeout_d = 1'b0;
        if (tmo_fire)        timeout_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    logic unused_clear;
    assign unused_clear = timeout_clear_i;
    assign tmo_fire     = 1'b0;
    assign timeout_o    = 1'b0;
`endif

    // A timeout fakes a zero-data ack to the owner while withdrawing the request from the slave.
    assign s_stb_o   = stb_raw && !tmo_fire;
    assign s_cyc_o   = cyc_raw && !tmo_fire;
    assign m0_ack_o  = own0 && (s_ack_i || tmo_fire);
    assign m1_ack_o  = own1 && (s_ack_i || tmo_fire);
    assign m0_data_o = (own0 && !tmo_fire) ? s_data_i : '0;
    assign m1_data_o = (own1 && !tmo_fire) ? s_data_i : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter; covers the timeout path when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] m0_addr_i = '0, m0_data_i = '0, m1_addr_i = '0, m1_data_i = '0;
    logic [3:0]  m0_sel_i = '0, m1_sel_i = '0;
    logic        m0_we_i = 1'b0, m0_stb_i = 1'b0, m0_cyc_i = 1'b0;
    logic        m1_we_i = 1'b0, m1_stb_i = 1'b0, m1_cyc_i = 1'b0;
    logic        m0_ack_o, m1_ack_o;
    logic [31:0] m0_data_o, m1_data_o;
    logic [31:0] s_addr_o, s_data_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o, s_stb_o, s_cyc_o;
    logic        s_ack_i = 1'b0;
    logic [31:0] s_data_i = '0;
    logic [1:0]  grant_o;
    logic        timeout_o;
    logic        timeout_clear_i = 1'b0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(
        .WB_DATA_WIDTH (32),
        .WB_ADDR_WIDTH (32),
        .WB_SEL_WIDTH  (4),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
        .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
        .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
        .s_ack_i(s_ack_i), .s_data_i(s_data_i),
        .grant_o(grant_o), .timeout_o(timeout_o), .timeout_clear_i(timeout_clear_i)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven there, outputs sampled at negedge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        @(negedge clk_i);
        check("rst_grant", 32'(grant_o), 32'h0);
        check("rst_s_cyc", 32'(s_cyc_o), 32'h0);
        check("rst_s_stb", 32'(s_stb_o), 32'h0);
        check("rst_s_addr", s_addr_o, 32'h0);
        check("rst_timeout", 32'(timeout_o), 32'h0);
        check("rst_m0_ack", 32'(m0_ack_o), 32'h0);

        // Single read by m0
        step();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h100; m0_sel_i = 4'hF;
        @(negedge clk_i);
        check("rd_wait_grant", 32'(grant_o), 32'h0);
        check("rd_wait_stb", 32'(s_stb_o), 32'h0);
        step();
        @(negedge clk_i);
        check("rd_grant", 32'(grant_o), 32'h1);
        check("rd_s_stb", 32'(s_stb_o), 32'h1);
        check("rd_s_addr", s_addr_o, 32'h100);
        check("rd_early_ack", 32'(m0_ack_o), 32'h0);
        step();
        step();
        s_ack_i = 1'b1; s_data_i = 32'hCAFEF00D;
        @(negedge clk_i);
        check("rd_m0_ack", 32'(m0_ack_o), 32'h1);
        check("rd_m0_data", m0_data_o, 32'hCAFEF00D);
        check("rd_m1_ack", 32'(m1_ack_o), 32'h0);
        check("rd_m1_data", m1_data_o, 32'h0);
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk_i);
        check("rd_drop_ack", 32'(m0_ack_o), 32'h0);
        step();
        @(negedge clk_i);
        check("rd_idle_grant", 32'(grant_o), 32'h0);

        // Simultaneous requests after reset
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h200;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h300;
        step();
        s_ack_i = 1'b1; s_data_i = 32'h1234_5678;
        @(negedge clk_i);
        check("tie_grant_m0", 32'(grant_o), 32'h1);
        check("tie_s_addr", s_addr_o, 32'h200);
        check("tie_m0_ack", 32'(m0_ack_o), 32'h1);
        check("tie_m1_ack", 32'(m1_ack_o), 32'h0);
        check("tie_m1_data", m1_data_o, 32'h0);
        step();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk_i);
        check("ho_still_m0", 32'(grant_o), 32'h1);
        check("ho_s_cyc_low", 32'(s_cyc_o), 32'h0);
        step();
        @(negedge clk_i);
        check("ho_grant_m1", 32'(grant_o), 32'h2);
        check("ho_s_addr", s_addr_o, 32'h300);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        @(negedge clk_i);
        check("tie2_idle", 32'(grant_o), 32'h0);
        step();
        @(negedge clk_i);
        check("tie2_grant_m0", 32'(grant_o), 32'h1);
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        step();
        step();
        m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
        step();
        @(negedge clk_i);
        check("tie3_grant_m1", 32'(grant_o), 32'h2);
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0;
        step();
        step();

        // Locked burst by m1 while m0 waits
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_addr_i = 32'h400;
        step();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h500;
        for (int i = 0; i < 4; i++) begin
            s_ack_i = 1'b1;
            @(negedge clk_i);
            check($sformatf("burst%0d_grant", i), 32'(grant_o), 32'h2);
            check($sformatf("burst%0d_m1_ack", i), 32'(m1_ack_o), 32'h1);
            check($sformatf("burst%0d_m0_ack", i), 32'(m0_ack_o), 32'h0);
            step();
            s_ack_i = 1'b0;
            step();
        end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        @(negedge clk_i);
        check("burst_end_grant", 32'(grant_o), 32'h2);
        step();
        @(negedge clk_i);
        check("burst_m0_grant", 32'(grant_o), 32'h1);
        check("burst_m0_addr", s_addr_o, 32'h500);

        // Reset during an m1 write stall
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_data_i = 32'h55;
        step();
        step();
        @(negedge clk_i);
        check("mrst_grant_m1", 32'(grant_o), 32'h2);
        check("mrst_s_we", 32'(s_we_o), 32'h1);
        check("mrst_s_data", s_data_o, 32'h55);
        rst_i = 1'b1; s_ack_i = 1'b1;
        @(negedge clk_i);
        check("mrst_ack_in_rst", 32'(m1_ack_o), 32'h0);
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mrst_grant", 32'(grant_o), 32'h0);
        check("mrst_s_cyc", 32'(s_cyc_o), 32'h0);
        check("mrst_m1_ack", 32'(m1_ack_o), 32'h0);
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        step();
        step();

`ifdef WB_ARB_TIMEOUT_EN
        // Stall timeout with limit 8
        do_reset();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_data_i = 32'hFFFF_FFFF;
        step();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            check($sformatf("tmo_stall%0d_ack", i), 32'(m0_ack_o), 32'h0);
            step();
        end
        @(negedge clk_i);
        check("tmo_ack", 32'(m0_ack_o), 32'h1);
        check("tmo_data", m0_data_o, 32'h0);
        check("tmo_s_stb", 32'(s_stb_o), 32'h0);
        step();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk_i);
        check("tmo_flag", 32'(timeout_o), 32'h1);
        step();
        step();
        @(negedge clk_i);
        check("tmo_sticky", 32'(timeout_o), 32'h1);
        timeout_clear_i = 1'b1;
        step();
        timeout_clear_i = 1'b0;
        @(negedge clk_i);
        check("tmo_cleared", 32'(timeout_o), 32'h0);
`else
        @(negedge clk_i);
        check("no_tmo_flag", 32'(timeout_o), 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
